// File: rtl/riscv_pkg.sv
// Shared encodings for the data-memory bus interface: transfer sizes,
// AHB transfer types and the bus FSM states.
package riscv_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10,
    ERR  = 2'b11
  } mem_state_t;

  // The reserved size encoding 2'b11 is handled as a word access everywhere.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'b11) ? SZ_WORD : size;
  endfunction

endpackage

// File: rtl/store_lane_gen.sv
// Store byte-lane generator: replicates store data across the 32-bit bus,
// builds the byte strobe and flags accesses that are not naturally aligned.
module store_lane_gen
  import riscv_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rs2,
  output logic [31:0] hwdata,
  output logic [3:0]  mask,
  output logic        misaligned
);

  // Lane replication, strobe and alignment check per access size.
  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    hwdata     = rs2;
    mask       = 4'b1111;
    misaligned = 1'b0;
    case (norm_size(size))
      SZ_BYTE: begin
        hwdata = {4{rs2[7:0]}};
        mask   = 4'b0001 << addr_lo;
      end
      SZ_HALF: begin
        hwdata     = {2{rs2[15:0]}};
        mask       = addr_lo[1] ? 4'b1100 : 4'b0011;
        misaligned = addr_lo[0];
      end
      default: begin
        misaligned = |addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_if.sv
// Data-memory bus interface: turns one load/store request into a single
// AHB-Lite transfer, returns load data / error status and stalls upstream.
module data_mem_if
  import riscv_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter logic [3:0]  HPROT_VAL  = 4'b0001
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  mem_req_in,
  input  logic                  mem_wr_in,
  input  logic                  flush_in,
  input  logic [ADDR_WIDTH-1:0] iadder_in,
  input  logic [31:0]           rs2_in,
  input  logic [1:0]            mem_size_in,
  output logic [ADDR_WIDTH-1:0] haddr_out,
  output logic [1:0]            htrans_out,
  output logic                  hwrite_out,
  output logic [2:0]            hsize_out,
  output logic [3:0]            hprot_out,
  output logic [31:0]           hwdata_out,
  output logic [3:0]            wr_mask_out,
  input  logic                  hready_in,
  input  logic                  hresp_in,
  input  logic [31:0]           hrdata_in,
  output logic [31:0]           dmdata_out,
  output logic                  ahb_resp_out,
  output logic                  misaligned_out,
  output logic                  stall_out
);

  mem_state_t  state, state_nxt;
  logic        accept;
  logic [31:0] lane_data;
  logic [3:0]  lane_mask;
  logic        lane_misaligned;

  store_lane_gen u_lanes (
    .size       (mem_size_in),
    .addr_lo    (iadder_in[1:0]),
    .rs2        (rs2_in),
    .hwdata     (lane_data),
    .mask       (lane_mask),
    .misaligned (lane_misaligned)
  );

  assign hprot_out = HPROT_VAL;

  // Next-state and stall decode; stall drops in the completion cycle.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    stall_out = 1'b0;
    case (state)
      IDLE: begin
        accept = mem_req_in & ~flush_in & ~lane_misaligned;
        if (accept) begin
          state_nxt = ADDR;
          stall_out = 1'b1;
        end
      end
      ADDR: begin
        stall_out = 1'b1;
        if (hready_in) state_nxt = DATA;
      end
      DATA: begin
        stall_out = ~hready_in;
        if (hready_in)     state_nxt = IDLE;
        else if (hresp_in) state_nxt = ERR;
      end
      ERR: begin
        stall_out = 1'b1;
        if (hready_in) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register; reset abandons any in-flight transfer.
  always_ff @(posedge clk_in or posedge rst_in) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  // Bus attribute, load-result and status registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      haddr_out      <= '0;
      htrans_out     <= HTRANS_IDLE;
      hwrite_out     <= 1'b0;
      hsize_out      <= 3'b000;
      hwdata_out     <= '0;
      wr_mask_out    <= 4'b0000;
      dmdata_out     <= '0;
      ahb_resp_out   <= 1'b0;
      misaligned_out <= 1'b0;
    end else begin
      misaligned_out <= (state == IDLE) & mem_req_in & ~flush_in & lane_misaligned;
      // Attributes are captured once and held until the next accepted request.
      if (accept) begin
        haddr_out   <= iadder_in;
        hwrite_out  <= mem_wr_in;
        hsize_out   <= {1'b0, norm_size(mem_size_in)};
        wr_mask_out <= mem_wr_in ? lane_mask : 4'b0000;
        hwdata_out  <= lane_data;
        htrans_out  <= HTRANS_NONSEQ;
      end else if (state == ADDR && hready_in) begin
        htrans_out <= HTRANS_IDLE;
      end
      // A late error seen together with hready still reports as an error.
      if (state == DATA && hready_in) begin
        ahb_resp_out <= hresp_in;
        if (!hresp_in && !hwrite_out) dmdata_out <= hrdata_in;
      end
      if (state == ERR && hready_in) ahb_resp_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_data_mem_if.sv
// Self-checking bench for data_mem_if: a reactive AHB slave plus a
// transaction-level reference model of lanes, latency and load results.
module tb_data_mem_if;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        mem_req_in, mem_wr_in, flush_in;
  logic [31:0] iadder_in, rs2_in;
  logic [1:0]  mem_size_in;
  logic [31:0] haddr_out;
  logic [1:0]  htrans_out;
  logic        hwrite_out;
  logic [2:0]  hsize_out;
  logic [3:0]  hprot_out;
  logic [31:0] hwdata_out;
  logic [3:0]  wr_mask_out;
  logic        hready_in, hresp_in;
  logic [31:0] hrdata_in;
  logic [31:0] dmdata_out;
  logic        ahb_resp_out, misaligned_out, stall_out;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_dmdata = '0;
  logic        exp_resp   = 1'b0;

  always #5 clk_in = ~clk_in;

  data_mem_if #(.ADDR_WIDTH(32), .HPROT_VAL(4'b0001)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .mem_req_in(mem_req_in), .mem_wr_in(mem_wr_in),
    .flush_in(flush_in), .iadder_in(iadder_in), .rs2_in(rs2_in), .mem_size_in(mem_size_in),
    .haddr_out(haddr_out), .htrans_out(htrans_out), .hwrite_out(hwrite_out),
    .hsize_out(hsize_out), .hprot_out(hprot_out), .hwdata_out(hwdata_out),
    .wr_mask_out(wr_mask_out), .hready_in(hready_in), .hresp_in(hresp_in),
    .hrdata_in(hrdata_in), .dmdata_out(dmdata_out), .ahb_resp_out(ahb_resp_out),
    .misaligned_out(misaligned_out), .stall_out(stall_out)
  );

  // One complete transfer: request cycle, address phase with aw wait states,
  // data phase with dw wait states (plus a two-cycle error response if err).
  task automatic txn(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                     input logic [31:0] rs2, input int aw, input int dw,
                     input logic err, input logic [31:0] rdata);
    int n, off, stalls, ncyc;
    logic [3:0]  e_mask;
    logic [31:0] e_data;
    logic [2:0]  e_size;
    logic        e_stall;
    n      = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    off    = (int'(addr[1:0]) / n) * n;
    e_mask = wr ? 4'(((1 << n) - 1) << off) : 4'b0000;
    for (int i = 0; i < 4; i++) e_data[8*i +: 8] = rs2[8*(i % n) +: 8];
    e_size = (size == 2'd3) ? 3'd2 : {1'b0, size};
    stalls = 0;

    @(negedge clk_in);
    mem_req_in = 1'b1; mem_wr_in = wr; flush_in = 1'b0; iadder_in = addr;
    rs2_in = rs2; mem_size_in = size; hready_in = 1'b1; hresp_in = 1'b0;
    #1;
    if (stall_out !== 1'b1) begin bad++; $display("FAIL req_stall: got %b want 1", stall_out); end
    total++;
    if (stall_out === 1'b1) stalls++;

    @(negedge clk_in);
    mem_req_in = 1'b0; rs2_in = $urandom; hready_in = (aw == 0);
    #1;
    if (htrans_out !== 2'b10) begin
      bad++; total++;
      $display("FAIL nonseq_cycle1: got %b want 10 (addr %h)", htrans_out, addr);
      return;
    end
    for (int w = 0; w <= aw; w++) begin
      if (w > 0) begin @(negedge clk_in); hready_in = (w == aw); #1; end
      if (htrans_out !== 2'b10 || haddr_out !== addr || hwrite_out !== wr || wr_mask_out !== e_mask
          || hprot_out !== 4'b0001 || stall_out !== 1'b1) begin
        bad++;
        $display("FAIL addr_phase: got tr=%b a=%h w=%b m=%b p=%b st=%b want tr=10 a=%h w=%b m=%b p=0001 st=1",
                 htrans_out, haddr_out, hwrite_out, wr_mask_out, hprot_out, stall_out, addr, wr, e_mask);
      end
      total++;
      if (size != 2'd3) begin
        if (hsize_out !== e_size) begin bad++; $display("FAIL hsize: got %b want %b", hsize_out, e_size); end
        total++;
      end
      if (stall_out === 1'b1) stalls++;
    end

    ncyc = err ? dw + 2 : dw + 1;
    for (int w = 0; w < ncyc; w++) begin
      @(negedge clk_in);
      hready_in = err ? (w == dw + 1) : (w == dw);
      hresp_in  = err && (w >= dw);
      hrdata_in = rdata;
      #1;
      e_stall = err ? 1'b1 : ~hready_in;
      if (htrans_out !== 2'b00 || haddr_out !== addr || wr_mask_out !== e_mask || stall_out !== e_stall) begin
        bad++;
        $display("FAIL data_phase: got tr=%b a=%h m=%b st=%b want tr=00 a=%h m=%b st=%b",
                 htrans_out, haddr_out, wr_mask_out, stall_out, addr, e_mask, e_stall);
      end
      total++;
      if (wr) begin
        if (hwdata_out !== e_data) begin bad++; $display("FAIL hwdata: got %h want %h", hwdata_out, e_data); end
        total++;
      end
      if (stall_out === 1'b1) stalls++;
    end

    if (err) exp_resp = 1'b1;
    else begin
      exp_resp = 1'b0;
      if (!wr) exp_dmdata = rdata;
    end

    @(negedge clk_in);
    hready_in = 1'b1; hresp_in = 1'b0; hrdata_in = $urandom;
    #1;
    if (dmdata_out !== exp_dmdata || ahb_resp_out !== exp_resp || stall_out !== 1'b0) begin
      bad++;
      $display("FAIL result: got d=%h r=%b st=%b want d=%h r=%b st=0",
               dmdata_out, ahb_resp_out, stall_out, exp_dmdata, exp_resp);
    end
    total++;
    if (stalls != 2 + aw + dw + (err ? 2 : 0)) begin
      bad++; $display("FAIL stall_len: got %0d want %0d", stalls, 2 + aw + dw + (err ? 2 : 0));
    end
    total++;
  endtask

  task automatic test_reset();
    #1;
    if (htrans_out !== 2'b00 || haddr_out !== '0 || hwdata_out !== '0 || wr_mask_out !== 4'b0
        || dmdata_out !== '0 || hwrite_out !== 1'b0 || ahb_resp_out !== 1'b0
        || misaligned_out !== 1'b0 || stall_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: tr=%b a=%h d=%h m=%b dm=%h w=%b r=%b mis=%b st=%b want all zero",
               htrans_out, haddr_out, hwdata_out, wr_mask_out, dmdata_out, hwrite_out,
               ahb_resp_out, misaligned_out, stall_out);
    end
    total++;
    @(negedge clk_in); rst_in = 1'b0;
    @(negedge clk_in); #1;
    if (htrans_out !== 2'b00 || stall_out !== 1'b0) begin
      bad++; $display("FAIL post_reset_idle: got tr=%b st=%b want 00 0", htrans_out, stall_out);
    end
    total++;
  endtask

  task automatic test_load_word();
    txn(1'b0, 2'd2, 32'h100, 32'h0, 0, 0, 1'b0, 32'hDEADBEEF);
  endtask

  task automatic test_store_byte();
    txn(1'b1, 2'd0, 32'h203, 32'h000000A5, 0, 0, 1'b0, 32'h0);
  endtask

  task automatic test_store_half_waits();
    txn(1'b1, 2'd1, 32'h202, 32'h1234BEEF, 0, 2, 1'b0, 32'h0);
  endtask

  task automatic test_load_error();
    txn(1'b0, 2'd2, 32'h300, 32'h0, 0, 0, 1'b1, 32'hBAD0BAD0);
    txn(1'b0, 2'd2, 32'h304, 32'h0, 0, 0, 1'b0, 32'h600DF00D);
  endtask

  task automatic test_misaligned_flush();
    @(negedge clk_in);
    mem_req_in = 1'b1; mem_wr_in = 1'b0; flush_in = 1'b0; iadder_in = 32'h102; mem_size_in = 2'd2;
    #1;
    if (stall_out !== 1'b0) begin bad++; $display("FAIL mis_stall: got %b want 0", stall_out); end
    total++;
    @(negedge clk_in); mem_req_in = 1'b0; #1;
    if (misaligned_out !== 1'b1 || htrans_out !== 2'b00) begin
      bad++; $display("FAIL mis_pulse: got mis=%b tr=%b want 1 00", misaligned_out, htrans_out);
    end
    total++;
    @(negedge clk_in); #1;
    if (misaligned_out !== 1'b0) begin bad++; $display("FAIL mis_one_cycle: got %b want 0", misaligned_out); end
    total++;
    @(negedge clk_in);
    mem_req_in = 1'b1; flush_in = 1'b1; iadder_in = 32'h400; mem_size_in = 2'd2;
    #1;
    if (stall_out !== 1'b0) begin bad++; $display("FAIL flush_stall: got %b want 0", stall_out); end
    total++;
    @(negedge clk_in); mem_req_in = 1'b0; flush_in = 1'b0; #1;
    if (htrans_out !== 2'b00 || misaligned_out !== 1'b0) begin
      bad++; $display("FAIL flush_no_xfer: got tr=%b mis=%b want 00 0", htrans_out, misaligned_out);
    end
    total++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk_in);
    mem_req_in = 1'b1; mem_wr_in = 1'b1; flush_in = 1'b0; iadder_in = 32'h500;
    rs2_in = 32'hCAFEF00D; mem_size_in = 2'd2; hready_in = 1'b1;
    @(negedge clk_in); mem_req_in = 1'b0; hready_in = 1'b0; #1;
    if (htrans_out !== 2'b10) begin bad++; $display("FAIL mid_addr: got %b want 10", htrans_out); end
    total++;
    #2 rst_in = 1'b1;
    #1;
    if (htrans_out !== 2'b00 || stall_out !== 1'b0 || haddr_out !== '0 || hwdata_out !== '0
        || wr_mask_out !== 4'b0 || hwrite_out !== 1'b0 || dmdata_out !== '0 || ahb_resp_out !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: tr=%b st=%b a=%h d=%h m=%b w=%b dm=%h r=%b want all zero",
               htrans_out, stall_out, haddr_out, hwdata_out, wr_mask_out, hwrite_out,
               dmdata_out, ahb_resp_out);
    end
    total++;
    @(negedge clk_in); rst_in = 1'b0; hready_in = 1'b1;
    exp_dmdata = '0; exp_resp = 1'b0;
    txn(1'b0, 2'd1, 32'h502, 32'h0, 0, 0, 1'b0, 32'h0000ABCD);
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      int          n;
      sz = 2'($urandom_range(0, 3));
      n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      a  = $urandom & ~32'(n - 1);
      txn(1'($urandom), sz, a, $urandom, $urandom_range(0, 2), $urandom_range(0, 2),
          ($urandom_range(0, 4) == 0), $urandom);
    end
  endtask

  initial begin
    rst_in = 1'b1; mem_req_in = 1'b0; mem_wr_in = 1'b0; flush_in = 1'b0;
    iadder_in = '0; rs2_in = '0; mem_size_in = 2'd0;
    hready_in = 1'b1; hresp_in = 1'b0; hrdata_in = '0;
    @(negedge clk_in);
    test_reset();
    test_load_word();
    test_store_byte();
    test_store_half_waits();
    test_load_error();
    test_misaligned_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_if.md
Name: data_mem_if

Overview:
- Data-memory bus interface stage between the execute/address stage and stage 3.
- Takes the load/store request produced from iadder/rs2 and runs one AHB-Lite single transfer per request (address phase, then data phase).
- Drives store byte lanes and masks. Returns load data and error status to stage 3's load unit (dmdata/ahb_resp). Stalls the pipeline while a transfer is outstanding.

Parameters:
ADDR_WIDTH, 32, width of haddr/iadder.
HPROT_VAL, 4'b0001, constant hprot driven on every transfer (data access).

Ports:
clk_in  input  1  pipeline clock
rst_in  input  1  asynchronous active-high reset
mem_req_in  input  1  load/store request valid (stage 2)
mem_wr_in  input  1  1=store, 0=load
flush_in  input  1  kill request not yet issued
iadder_in  input  ADDR_WIDTH  effective address
rs2_in  input  32  store data
mem_size_in  input  2  00 byte, 01 half, 10 word, 11 treated as word
haddr_out  output  ADDR_WIDTH  AHB address
htrans_out  output  2  IDLE=00 / NONSEQ=10
hwrite_out  output  1  AHB write
hsize_out  output  3  {1'b0,size}
hprot_out  output  4  HPROT_VAL
hwdata_out  output  32  lane-replicated store data (data phase)
wr_mask_out  output  4  byte-lane strobe
hready_in  input  1  AHB ready
hresp_in  input  1  AHB error
hrdata_in  input  32  AHB read data
dmdata_out  output  32  registered load word to stage 3
ahb_resp_out  output  1  registered error flag to stage 3
misaligned_out  output  1  one-cycle misaligned-access pulse
stall_out  output  1  hold upstream pipeline

Behaviour:
- Reset (async, immediate): state IDLE; htrans_out=00; haddr_out, hwdata_out, wr_mask_out, dmdata_out = 0; hwrite_out, ahb_resp_out, misaligned_out = 0. Any in-flight transfer is abandoned.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
  - Registered pulse on misaligned_out next cycle.
  - No bus transfer, no stall.
- accept = IDLE & mem_req_in & !flush_in & aligned.
- States:
  - IDLE: on accept, register haddr/hwrite/hsize/mask/wdata, htrans_out<=NONSEQ, go ADDR.
  - ADDR: address phase; hold all address signals while !hready_in. On hready_in: htrans_out<=IDLE, go DATA.
  - DATA: hwdata_out stable.
    - hready_in & !hresp_in: dmdata_out<=hrdata_in (loads only; stores leave it unchanged), ahb_resp_out<=0, go IDLE.
    - hresp_in & !hready_in (first error cycle): go ERR.
  - ERR: on hready_in: ahb_resp_out<=1, go IDLE.
- ahb_resp_out holds until the next completing transfer.
- Bus attribute ordering: hwrite_out/hsize_out/haddr_out/wr_mask_out remain at the last transfer's values when htrans_out=IDLE.
- Store lanes:
  - byte: hwdata_out={4{rs2[7:0]}}, mask=4'b0001<<addr[1:0].
  - half: hwdata_out={2{rs2[15:0]}}, mask=addr[1]?1100:0011.
  - word: hwdata_out=rs2, mask=1111.
  - Loads: mask=0000.
- stall_out (combinational) = accept | ADDR | ERR | (DATA & !hready_in).
  - Stall drops in the completion cycle, so the instruction enters stage 3 on the same edge dmdata_out updates.
- Latency with a zero-wait slave: request cycle 0, ADDR cycle 1, DATA cycle 2, data visible to stage 3 in cycle 3. Stall is high in cycles 0-1.
- Each slave wait state extends the stall by one cycle.
- flush_in only blocks acceptance in IDLE. Once ADDR is entered the transfer completes normally (no AHB abort). The result is discarded by stage 3.
- A new request is never accepted before IDLE is reached, so there is at most one outstanding transfer.

Decomposition:
- Shared package riscv_pkg:
  - size encodings (SZ_BYTE/HALF/WORD)
  - HTRANS_IDLE/HTRANS_NONSEQ
  - state enum (IDLE, ADDR, DATA, ERR)
- Sub-module store_lane_gen (combinational): size, addr[1:0], rs2 -> hwdata, mask, misaligned. It can be reused by a future instruction-fetch/DMA port.

Test Plan:
- Load word, addr 0x100, slave 0-wait, hrdata 0xDEADBEEF -> htrans NONSEQ cycle 1, stall high cycles 0-1, dmdata_out=0xDEADBEEF cycle 3, ahb_resp_out=0.
- Store byte rs2=0x000000A5 at 0x203 -> hwdata_out=0xA5A5A5A5, wr_mask_out=1000, hwrite_out=1, hsize_out=000.
- Store half at 0x202, slave inserts 2 wait states in data phase -> stall high 4 cycles total, hwdata stable throughout, mask=1100.
- Load from 0x300, slave two-cycle error response -> ERR visited, ahb_resp_out=1 after completion, dmdata_out unchanged. A following good load clears ahb_resp_out.
- Word load at 0x102 -> misaligned_out pulses 1 cycle, htrans stays IDLE, stall_out low. flush_in with request -> no transfer.
- rst_in asserted during ADDR of a store -> htrans_out=00, stall_out=0, all outputs zero immediately (asynchronous).
